// File: rtl/spi_master_pkg.sv
// Shared SPI master types and constants: TX FSM states, mode encodings and
// the bit-count to shift-count conversion used when a transfer is started.
package spi_master_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        TRANSMIT  = 2'd1,
        WAIT_DATA = 2'd2
    } tx_state_e;

    localparam logic SPI_STD  = 1'b0;
    localparam logic SPI_QUAD = 1'b1;

    // Quad mode moves four bits per shift; leftover bits below a nibble are dropped.
    function automatic logic [31:0] bits_to_shifts(input logic [31:0] bits, input logic quad);
        return (quad == SPI_QUAD) ? (bits >> 2) : bits;
    endfunction

endpackage

// File: rtl/spi_master_tx_shreg.sv
// TX load/shift register with sdo lane mapping. The quad path exists only
// when SPI_MASTER_TX_QUAD_EN is defined.
module spi_master_tx_shreg #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  shift_i,
`ifdef SPI_MASTER_TX_QUAD_EN
    input  logic                  quad_i,
`endif
    output logic                  sdo0_o,
    output logic                  sdo1_o,
    output logic                  sdo2_o,
    output logic                  sdo3_o
);
    import spi_master_pkg::*;

    logic [DATA_WIDTH-1:0] data_q;

    // A load wins over a shift: at a word boundary the new word replaces the spent one.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= data_i;
        end else if (shift_i) begin
`ifdef SPI_MASTER_TX_QUAD_EN
            data_q <= (quad_i == SPI_QUAD) ? {data_q[DATA_WIDTH-5:0], 4'b0000}
                                           : {data_q[DATA_WIDTH-2:0], 1'b0};
`else
            data_q <= {data_q[DATA_WIDTH-2:0], 1'b0};
`endif
        end
    end

`ifdef SPI_MASTER_TX_QUAD_EN
    always_comb begin
        if (quad_i == SPI_QUAD) begin
            {sdo3_o, sdo2_o, sdo1_o, sdo0_o} = data_q[DATA_WIDTH-1 -: 4];
        end else begin
            {sdo3_o, sdo2_o, sdo1_o} = 3'b000;
            sdo0_o = data_q[DATA_WIDTH-1];
        end
    end
`else
    assign sdo0_o = data_q[DATA_WIDTH-1];
    assign sdo1_o = 1'b0;
    assign sdo2_o = 1'b0;
    assign sdo3_o = 1'b0;
`endif

endmodule

// File: rtl/spi_master_tx.sv
// SPI master transmit shifter: pops FIFO words and serialises them on sdo.
// Quad (4-bit) mode is built only when SPI_MASTER_TX_QUAD_EN is defined.
module spi_master_tx #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  en_quad_i,
    input  logic [CNT_WIDTH-1:0]  counter_in_i,
    input  logic                  tx_edge_i,
    input  logic [DATA_WIDTH-1:0] txdata_i,
    input  logic                  txdata_valid_i,
    output logic                  txdata_ready_o,
    output logic                  sdo0_o,
    output logic                  sdo1_o,
    output logic                  sdo2_o,
    output logic                  sdo3_o,
    output logic                  clk_en_o,
    output logic                  tx_done_o
);
    import spi_master_pkg::*;

    localparam int              SH_W      = $clog2(DATA_WIDTH);
    localparam logic [SH_W-1:0] LAST_STD  = SH_W'(DATA_WIDTH - 1);
    localparam logic [SH_W-1:0] LAST_QUAD = SH_W'(DATA_WIDTH / 4 - 1);

    tx_state_e            state_q, state_d;
    logic [CNT_WIDTH-1:0] bit_cnt_q, bit_cnt_d, trgt_q, trgt_d, trgt_start, cnt_nxt;
    logic [SH_W-1:0]      sh_cnt_q, sh_cnt_d;
    logic                 quad_start, quad_cur;
    logic                 load_ok, shift, done_d, done_q, clk_en_q, last, word_end;

`ifdef SPI_MASTER_TX_QUAD_EN
    logic quad_q;

    assign quad_start = en_quad_i;
    assign quad_cur   = quad_q;

    always_ff @(posedge clk_i) begin
        if (rst_i)                        quad_q <= SPI_STD;
        else if (state_q == IDLE && en_i) quad_q <= en_quad_i;
    end
`else
    logic unused_en_quad;

    assign unused_en_quad = en_quad_i;
    assign quad_start     = SPI_STD;
    assign quad_cur       = SPI_STD;
`endif

    assign trgt_start = CNT_WIDTH'(bits_to_shifts(32'(counter_in_i), quad_start));
    assign cnt_nxt    = bit_cnt_q + CNT_WIDTH'(1);
    assign last       = (cnt_nxt == trgt_q);
    // Shifts within the current word; avoids a modulo when DATA_WIDTH is not a power of two.
    assign word_end   = (sh_cnt_q == ((quad_cur == SPI_QUAD) ? LAST_QUAD : LAST_STD));

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sh_cnt_d  = sh_cnt_q;
        trgt_d    = trgt_q;
        load_ok   = 1'b0;
        shift     = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (en_i) begin
                    trgt_d    = trgt_start;
                    bit_cnt_d = '0;
                    sh_cnt_d  = '0;
                    if (trgt_start == '0) begin
                        done_d = 1'b1;
                    end else begin
                        load_ok = 1'b1;
                        state_d = txdata_valid_i ? TRANSMIT : WAIT_DATA;
                    end
                end
            end
            TRANSMIT: begin
                if (tx_edge_i) begin
                    shift     = 1'b1;
                    bit_cnt_d = cnt_nxt;
                    sh_cnt_d  = sh_cnt_q + SH_W'(1);
                    if (last) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else if (word_end) begin
                        load_ok  = 1'b1;
                        sh_cnt_d = '0;
                        if (!txdata_valid_i) state_d = WAIT_DATA;
                    end
                end
            end
            WAIT_DATA: begin
                load_ok = 1'b1;
                if (txdata_valid_i) state_d = TRANSMIT;
            end
            default: state_d = IDLE;
        endcase
    end

    assign txdata_ready_o = load_ok & txdata_valid_i & ~rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            sh_cnt_q  <= '0;
            trgt_q    <= '0;
            done_q    <= 1'b0;
            clk_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            sh_cnt_q  <= sh_cnt_d;
            trgt_q    <= trgt_d;
            done_q    <= done_d;
            clk_en_q  <= (state_q == TRANSMIT);
        end
    end

    assign tx_done_o = done_q;
    assign clk_en_o  = clk_en_q;

    spi_master_tx_shreg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_shreg (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (txdata_ready_o),
        .data_i  (txdata_i),
        .shift_i (shift),
`ifdef SPI_MASTER_TX_QUAD_EN
        .quad_i  (quad_q),
`endif
        .sdo0_o  (sdo0_o),
        .sdo1_o  (sdo1_o),
        .sdo2_o  (sdo2_o),
        .sdo3_o  (sdo3_o)
    );

endmodule

// File: doc/spi_master_tx.md
# spi_master_tx

Transmit shifter of the SPI master: pops 32-bit words from the TX FIFO via valid/ready and serialises them onto the SPI data-out lines in standard (1-bit) or quad (4-bit) mode. It sits directly downstream of the TX `spi_master_fifo` and alongside the SPI clock generator. The clock generator supplies one `tx_edge_i` pulse per SCLK launch edge, and this block gates SCLK via `clk_en_o`. It is started by the controller FSM and reports completion with `tx_done_o`.

## Interface
- `DATA_WIDTH`, 32: FIFO word width; must be a multiple of 4.
- `CNT_WIDTH`, 16: width of the bit-count input.
- `clk_i` in 1: system clock.
- `rst_i` in 1: reset, synchronous and active-high, sampled on rising edge of `clk_i`.
- `en_i` in 1: start pulse; honoured only in IDLE.
- `en_quad_i` in 1: 1 = quad mode, 0 = standard; sampled with `en_i`.
- `counter_in_i` in CNT_WIDTH: total bits to send; sampled with `en_i`.
- `tx_edge_i` in 1: single-cycle pulse from the clock generator marking an SCLK launch edge.
- `txdata_i` in DATA_WIDTH: FIFO `data_o`.
- `txdata_valid_i` in 1: FIFO `valid_o`.
- `txdata_ready_o` out 1: FIFO `ready_i`; asserting it pops one word.
- `sdo0_o`..`sdo3_o` out 1 each: serial data outputs.
- `clk_en_o` out 1: SCLK enable to the clock generator.
- `tx_done_o` out 1: one-cycle completion pulse.

## Operation
- States: IDLE, TRANSMIT, WAIT_DATA.
- Registers:
  - `data_q`: DATA_WIDTH shift register.
  - `bit_cnt_q`: CNT_WIDTH, counts shifts.
  - `trgt_q`: CNT_WIDTH, target shift count.
  - `quad_q`: latched mode.
- `trgt_q` is latched at start: `counter_in_i` in standard mode, `counter_in_i >> 2` in quad mode. Residual bits (`counter_in_i[1:0]`) in quad mode are dropped.
- Shifts per word: WSHIFT = DATA_WIDTH in standard mode, DATA_WIDTH/4 in quad mode.
- IDLE:
  - `en_i` with `trgt == 0`: pulse `tx_done_o` next cycle and stay IDLE. No pop.
  - `en_i` with `txdata_valid_i`: `txdata_ready_o = 1` combinationally, load `txdata_i` into `data_q`, clear `bit_cnt_q`, go to TRANSMIT.
  - `en_i` without valid: go to WAIT_DATA.
- TRANSMIT: `clk_en_o = 1`. On each `tx_edge_i`:
  - Shift `data_q` left by 1 (standard) or 4 (quad), zero-filled.
  - Increment `bit_cnt_q`.
  - If `bit_cnt_q + 1 == trgt_q`: pulse `tx_done_o`, go to IDLE.
  - Else if `(bit_cnt_q + 1) mod WSHIFT == 0` (word boundary): if `txdata_valid_i`, pop and load in the same cycle (combinational ready) and stay in TRANSMIT; otherwise go to WAIT_DATA.
- WAIT_DATA: `clk_en_o = 0`; `tx_edge_i` is ignored. When `txdata_valid_i` is seen: pop, load, go to TRANSMIT.
- Output mapping:
  - Standard: `sdo0_o = data_q[MSB]`; `sdo1_o`..`sdo3_o` = 0.
  - Quad: `sdo3_o..sdo0_o = data_q[MSB:MSB-3]`.
- `en_i` outside IDLE is ignored. The block pops at most one word per cycle and never pops after the final shift.
- Words are only partially consumed when `trgt` is not a multiple of WSHIFT; the unused low bits are discarded.

## Timing
- Reset values:
  - State IDLE.
  - `data_q`, `bit_cnt_q`, `trgt_q`, `quad_q` = 0.
  - All sdo outputs = 0; `clk_en_o`, `tx_done_o`, `txdata_ready_o` = 0.
- Reset mid-transfer aborts immediately. No `tx_done_o` and no further pops.
- The first bit is valid on sdo one cycle after the load, i.e. before the first `tx_edge_i`.
- `clk_en_o` is registered: it rises the cycle after entering TRANSMIT and falls the cycle after leaving it.
- `tx_done_o` asserts the cycle after the final `tx_edge_i`.
- `txdata_ready_o` is combinational: `(state allows load) & txdata_valid_i`. It has no combinational path from `txdata_valid_i` back to `txdata_valid_i`.
- `bit_cnt_q` does not wrap: the maximum transfer is 2^CNT_WIDTH − 1 bits.

## Configuration
- `SPI_MASTER_TX_QUAD_EN`:
  - Defined: quad mode as described.
  - Undefined: `en_quad_i` is ignored (treated as 0), `sdo1_o`..`sdo3_o` are tied to 0, and the 4-bit shift path and `quad_q` are removed.

## Structure
- `spi_master_pkg` holds:
  - the `tx_state_e` enum (IDLE, TRANSMIT, WAIT_DATA);
  - the shared SPI mode constants (`SPI_STD`, `SPI_QUAD`);
  - a `bits_to_shifts` function.
- One sub-module, `spi_master_tx_shreg`, contains the load/shift register and the sdo mapping. The FSM and counters stay in the top level.

## Test plan
- Standard mode, count 8, word 0xA5000000: sdo0 sequence 1,0,1,0,0,1,0,1 over 8 edges; `tx_done_o` one cycle after the 8th edge; exactly one pop.
- Standard mode, count 64, FIFO preloaded with 0xDEADBEEF and 0x12345678: second pop occurs in the same cycle as the 32nd edge; `clk_en_o` never drops; 64 bits match.
- Stall, count 64, second word arrives 10 cycles late: WAIT_DATA is entered, `clk_en_o` is low for the gap, edges in the gap have no effect, and the bit stream is unbroken.
- Quad mode, count 16, word 0x1234_0000: nibbles on sdo3..0 are 1, 2, 3, 4; done after 4 edges. With the macro undefined, standard output results.
- `rst_i` asserted after 5 of 32 edges: all outputs 0 the next cycle, no `tx_done_o`; a new `en_i` then runs a clean transfer.
- count 0 with `en_i`: `tx_done_o` the next cycle, `txdata_ready_o` never asserted, `clk_en_o` stays 0.
